// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage and control unit
package fetch_pkg;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - next-PC select: sequential or redirect with bit 0 cleared
// FETCH_MISALIGN_TRAP_EN adds the misaligned-target detect output.
module pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            br_sel,
  input  logic [XLEN-1:0] alu_data,
  output logic [XLEN-1:0] next_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  , output logic          misalign
`endif
);

  logic [XLEN-1:0] target;

  // JALR semantics: the redirect target never has bit 0 set
  assign target  = alu_data & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign next_pc = br_sel ? target : pc + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = br_sel & alu_data[1];
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and req/ready + rvalid instruction fetch FSM
// FETCH_MISALIGN_TRAP_EN adds a sticky misalign_trap output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit,
  input  logic            br_sel,
  input  logic [XLEN-1:0] alu_data,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_four
`ifdef FETCH_MISALIGN_TRAP_EN
  , output logic          misalign_trap
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q;
  logic            pc_load, instr_load, trap_set, trap_q;
  logic            misalign;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc       (pc_q),
    .br_sel   (br_sel),
    .alu_data (alu_data),
    .next_pc  (pc_d)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign (misalign)
`endif
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

  // A trapped core parks in S_HOLD with nothing valid to execute
  assign instr_valid = (state_q == S_HOLD) && !trap_q;
  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_four     = pc_q + XLEN'(4);
  assign instr       = instr_valid ? instr_q : NOP_INSN;
  assign opcode      = instr[6:0];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
`endif

  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    trap_set   = 1'b0;
    case (state_q)
      S_REQ: begin
        if (imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_load = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (commit && instr_valid) begin
          pc_load = 1'b1;
          if (misalign) trap_set = 1'b1;
          else          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSN;
      trap_q  <= 1'b0;
    end else begin
      if (pc_load)    pc_q    <= pc_d;
      if (instr_load) instr_q <= imem_rdata;
      if (trap_set)   trap_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
// Covers FETCH_MISALIGN_TRAP_EN when the macro is defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit = 1'b0, br_sel = 1'b0;
  logic [31:0] alu_data = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc, pc_four;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .br_sel      (br_sel),
    .alu_data    (alu_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_trap (misalign_trap),
`endif
    .pc_four     (pc_four)
  );

  typedef struct {
    logic        rst, commit, br_sel;
    logic [31:0] alu;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc_four;
  } vec_t;

  vec_t v[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  initial begin
    //                 rst commit br  alu           rdy rv  rdata          req addr           vld instr          pc             pc_four
    v.push_back(vec_t'{1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 1, 32'h0050_0093,  0, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0050_0093, 32'h0,          32'h4});
    v.push_back(vec_t'{0, 1, 1, 32'h105,        0, 0, 32'h0,          0, 32'h0,          1, 32'h0050_0093, 32'h0,          32'h4});
    v.push_back(vec_t'{0, 1, 1, 32'h500,        0, 0, 32'h0,          1, 32'h104,        0, NOP,           32'h104,        32'h108});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  1, 32'h104,        0, NOP,           32'h104,        32'h108});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h104,        0, NOP,           32'h104,        32'h108});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,        0, NOP,           32'h104,        32'h108});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 1, 32'hFE00_0EE3,  0, 32'h104,        0, NOP,           32'h104,        32'h108});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h104,        1, 32'hFE00_0EE3, 32'h104,        32'h108});
    v.push_back(vec_t'{0, 1, 1, 32'hFFFF_FFFD,  0, 0, 32'h0,          0, 32'h104,        1, 32'hFE00_0EE3, 32'h104,        32'h108});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, NOP,           32'hFFFF_FFFC,  32'h0});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 1, 32'h0000_006F,  0, 32'hFFFF_FFFC,  0, NOP,           32'hFFFF_FFFC,  32'h0});
    v.push_back(vec_t'{0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'hFFFF_FFFC,  1, 32'h0000_006F, 32'hFFFF_FFFC,  32'h0});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 1, 32'h0010_0073,  0, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0010_0073, 32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,          0, NOP,           32'h4,          32'h8});
    v.push_back(vec_t'{1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 1, 32'hCAFE_F00D,  1, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 1, 32'h1234_5678,  1, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 1, 32'h0000_0037,  0, 32'h0,          0, NOP,           32'h0,          32'h4});
    v.push_back(vec_t'{0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0037, 32'h0,          32'h4});

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      rst         = v[i].rst;
      commit      = v[i].commit;
      br_sel      = v[i].br_sel;
      alu_data    = v[i].alu;
      imem_ready  = v[i].ready;
      imem_rvalid = v[i].rvalid;
      imem_rdata  = v[i].rdata;
      #1;
      check($sformatf("v%0d imem_req", i),    {31'b0, imem_req},    {31'b0, v[i].e_req});
      check($sformatf("v%0d imem_addr", i),   imem_addr,            v[i].e_addr);
      check($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, v[i].e_valid});
      check($sformatf("v%0d instr", i),       instr,                v[i].e_instr);
      check($sformatf("v%0d opcode", i),      {25'b0, opcode},      {25'b0, v[i].e_instr[6:0]});
      check($sformatf("v%0d pc", i),          pc,                   v[i].e_pc);
      check($sformatf("v%0d pc_four", i),     pc_four,              v[i].e_pc_four);
    end

    // Misaligned redirect from S_HOLD at pc 0
    @(negedge clk);
    commit = 1'b1; br_sel = 1'b1; alu_data = 32'h102;
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    commit = 1'b0; br_sel = 1'b0; alu_data = 32'h0;
    imem_ready = 1'b1;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap set",       {31'b0, misalign_trap}, 32'h1);
    check("trap pc",        pc,                     32'h102);
    check("trap valid",     {31'b0, instr_valid},   32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("trap req c%0d", k), {31'b0, imem_req}, 32'h0);
      @(negedge clk);
      imem_rvalid = 1'b1; commit = 1'b1;
      #1;
      check($sformatf("trap sticky c%0d", k), {31'b0, misalign_trap}, 32'h1);
    end
    @(negedge clk);
    rst = 1'b1; commit = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("trap cleared", {31'b0, misalign_trap}, 32'h0);
    check("post-trap req", {31'b0, imem_req},     32'h1);
`else
    check("misalign req",  {31'b0, imem_req}, 32'h1);
    check("misalign addr", imem_addr,         32'h102);
    begin
      logic got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = (k == 2);
        imem_rdata  = (k == 2) ? 32'h0000_0517 : 32'hBAD0_BAD0;
        #1;
        got = instr_valid;
      end
      check("slow rvalid seen", {31'b0, got}, 32'h1);
      check("slow instr",   instr,   32'h0000_0517);
      check("slow pc",      pc,      32'h102);
      check("slow pc_four", pc_four, 32'h106);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Owns the PC register and fetches instructions from a variable-latency instruction memory over a req/ready + rvalid handshake.
- Presents the instruction, its opcode, pc and pc_four to decode/execute, and holds them until the core signals commit.
- On commit, computes the next PC from the control unit's br_sel and the ALU target, then fetches again.

Parameters:
- XLEN, 32: PC and target width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- commit  in  1  current instruction completes this cycle; advance PC.
- br_sel  in  1  from control unit; 1 = redirect to alu_data, 0 = sequential.
- alu_data  in  XLEN  branch/jump target computed by ALU.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction; NOP (32'h0000_0013) when instr_valid=0.
- opcode  out  7  instr[6:0], feeds control unit.
- instr_valid  out  1  instr/pc are valid for execution.
- pc  out  XLEN  address of held instruction.
- pc_four  out  XLEN  pc + 4, for JAL/JALR writeback.

Behaviour:
- FSM states: S_REQ, S_WAIT, S_HOLD.
- Reset values, asynchronous on rst=1:
  - pc=RESET_PC, state=S_REQ, instr register=NOP, instr_valid=0.
  - imem_req=0 while rst=1.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 -> S_WAIT; otherwise stay, holding request and address stable.
  - imem_rvalid in S_REQ is ignored.
- S_WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> latch imem_rdata into instr, go to S_HOLD.
  - rvalid is accepted no earlier than the cycle after the ready handshake.
- S_HOLD:
  - instr_valid=1.
  - commit=0 -> hold everything.
  - commit=1 -> pc <= br_sel ? {alu_data[XLEN-1:1],1'b0} : pc+4; instr_valid <= 0; go to S_REQ.
  - Bit 0 of the target is cleared per JALR semantics.
- commit outside S_HOLD is ignored; br_sel and alu_data are only sampled on a valid commit.
- Latency:
  - First imem_req is in the first cycle after rst deasserts.
  - Minimum fetch-to-valid is 2 cycles (REQ with ready=1, then WAIT with rvalid=1).
  - Commit-to-next-req is 1 cycle (registered PC).
- Arithmetic: pc+4 is modulo 2^XLEN; 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- pc_four is combinational from the pc register.
- Reset mid-fetch: the outstanding request is abandoned. The memory shares rst and drops it; no stale rvalid is expected.
- The misaligned target (bit 1 set) is fetched as-is unless the optional feature is compiled in.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output misalign_trap (1 bit, reset 0).
  - On commit with br_sel=1 and alu_data[1]=1: misalign_trap is set and sticky until rst; pc is loaded with the target; FSM parks in S_HOLD with instr_valid=0 and imem_req=0.
- Disabled: no port; the target is used as computed.

Decomposition:
- fetch_pkg holds: state enum fetch_state_t {S_REQ, S_WAIT, S_HOLD}, constant NOP_INSN = 32'h0000_0013, and opcode constants shared with the control unit (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
- One natural combinational sub-module: pc_next, computing the next PC from pc, br_sel and alu_data, including bit-0 clear and the optional misalign detect.

Test Plan:
- Reset release, imem_ready=1, rvalid next cycle with rdata=32'h00500093 -> imem_addr=0x0, then instr_valid=1, opcode=7'h13, pc=0x0, pc_four=0x4.
- Ready withheld 3 cycles -> imem_req stays 1 with constant imem_addr for 3 cycles; instr_valid=0 and instr=NOP throughout.
- Commit with br_sel=1, alu_data=0x0000_0105 -> next imem_addr=0x0000_0104 (bit 0 cleared), pc_four=0x108 once valid.
- pc=0xFFFF_FFFC, commit with br_sel=0 -> next imem_addr=0x0000_0000.
- rst asserted while in S_WAIT, and rvalid pulses in S_REQ after release -> instr_valid stays 0, pc=RESET_PC, stray rvalid ignored.
- FETCH_MISALIGN_TRAP_EN defined, commit with br_sel=1, alu_data=0x102 -> misalign_trap=1, imem_req=0 thereafter until rst.
